// File: rtl/dm_dac_serializer.sv
// Serial DAC frame generator for the deformable-mirror actuator pads (SCLK/SDIN/SYNC_n/LDAC_n).
// Optional DM_DAC_AUTO_LDAC_EN: every completed frame requests an LDAC_n pulse after its GAP.
module dm_dac_serializer #(
  parameter int WORD_BITS = 24,
  parameter int DIV       = 2,
  parameter int GAP_CYC   = 4,
  parameter int LDAC_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 ldac_req,
  output logic                 busy,
  output logic                 frame_done,
  output logic [3:0]           pad_d
);

  localparam int MAXC = (DIV > GAP_CYC) ? ((DIV > LDAC_CYC) ? DIV : LDAC_CYC)
                                        : ((GAP_CYC > LDAC_CYC) ? GAP_CYC : LDAC_CYC);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BW = $clog2(WORD_BITS);

  localparam logic [CW-1:0] DIV_T  = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_T  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] LDAC_T = CW'(LDAC_CYC - 1);
  localparam logic [BW-1:0] BIT_T  = BW'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT_HI, S_SHIFT_LO, S_GAP, S_LDAC
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [WORD_BITS-1:0] sr, sr_nxt;
  logic                 ldac_pending, pend_nxt, pend_clr;
  logic                 done_nxt, sync_n_nxt;
  logic [3:0]           pad_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      sr           <= '0;
      ldac_pending <= 1'b0;
      pad_d        <= 4'b1100;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_cnt      <= bit_nxt;
      sr           <= sr_nxt;
      ldac_pending <= pend_nxt;
      pad_d        <= pad_nxt;
      in_ready     <= (state_nxt == S_IDLE);
      busy         <= (state_nxt != S_IDLE);
      frame_done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_cnt;
    sr_nxt    = sr;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (in_valid && in_ready) begin
          sr_nxt    = in_data;
          bit_nxt   = '0;
          state_nxt = S_SETUP;
        end else if (ldac_pending) begin
          state_nxt = S_LDAC;
        end
      end
      S_SETUP: if (cnt == DIV_T) begin
        cnt_nxt   = '0;
        state_nxt = S_SHIFT_HI;
      end
      S_SHIFT_HI: if (cnt == DIV_T) begin
        cnt_nxt   = '0;
        state_nxt = S_SHIFT_LO;
      end
      S_SHIFT_LO: if (cnt == DIV_T) begin
        cnt_nxt = '0;
        if (bit_cnt == BIT_T) begin
          state_nxt = S_GAP;
          sr_nxt    = '0;
          done_nxt  = 1'b1;
        end else begin
          // next bit appears together with the SCLK rising edge
          bit_nxt   = bit_cnt + 1'b1;
          sr_nxt    = {sr[WORD_BITS-2:0], 1'b0};
          state_nxt = S_SHIFT_HI;
        end
      end
      S_GAP: if (cnt == GAP_T) begin
        cnt_nxt   = '0;
        state_nxt = ldac_pending ? S_LDAC : S_IDLE;
      end
      S_LDAC: if (cnt == LDAC_T) begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // clearing on LDAC entry lets a same-cycle request survive for a later pass
    pend_clr = (state_nxt == S_LDAC) && (state != S_LDAC);
`ifdef DM_DAC_AUTO_LDAC_EN
    pend_nxt = ldac_req | done_nxt | (ldac_pending & ~pend_clr);
`else
    pend_nxt = ldac_req | (ldac_pending & ~pend_clr);
`endif

    sync_n_nxt = (state_nxt == S_IDLE) || (state_nxt == S_GAP) || (state_nxt == S_LDAC);
    pad_nxt    = {state_nxt != S_LDAC, sync_n_nxt,
                  ~sync_n_nxt & sr_nxt[WORD_BITS-1], state_nxt == S_SHIFT_HI};
  end

endmodule

// File: tb/tb_dm_dac_serializer.sv
// Directed bench for dm_dac_serializer at default parameters (DIV=2, WORD_BITS=24, GAP=4, LDAC=2).
module tb_dm_dac_serializer;

`ifdef DM_DAC_AUTO_LDAC_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ldac_req = 1'b0;
  logic        busy;
  logic        frame_done;
  logic [3:0]  pad_d;

  int checks = 0;
  int errors = 0;

  dm_dac_serializer u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ldac_req(ldac_req), .busy(busy), .frame_done(frame_done), .pad_d(pad_d)
  );

  always #5 clk = ~clk;

  // pad monitor, sampled on the falling clock edge
  int          cyc = 0;
  logic        p_sclk = 1'b0, p_sdin = 1'b0, p_sync = 1'b1, p_ldac = 1'b1;
  logic [31:0] word = '0, last_word = '0, prev_word = '0;
  int nbits = 0, last_nbits = 0, low_cnt = 0, last_low = 0;
  int fall_cyc = 0, fall_prev = 0, rise_cyc = 0, n_frames = 0;
  int ldac_fall = 0, ldac_w = 0, ldac_width = 0, n_ldac = 0;
  int n_done = 0, sdin_viol = 0, overlap = 0, rdy_err = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (p_sync && !pad_d[2]) begin
      fall_prev = fall_cyc; fall_cyc = cyc; word = '0; nbits = 0; low_cnt = 1;
    end else if (!pad_d[2]) low_cnt++;
    if (!p_sync && pad_d[2]) begin
      prev_word = last_word; last_word = word; last_nbits = nbits; last_low = low_cnt;
      rise_cyc = cyc; n_frames++;
    end
    if (!pad_d[2] && p_sclk && !pad_d[0]) begin word = {word[30:0], pad_d[1]}; nbits++; end
    if (!pad_d[2] && !p_sync && pad_d[1] !== p_sdin && !(pad_d[0] && !p_sclk)) sdin_viol++;
    if (p_ldac && !pad_d[3]) begin ldac_fall = cyc; ldac_w = 1; n_ldac++; end
    else if (!pad_d[3]) ldac_w++;
    if (!p_ldac && pad_d[3]) ldac_width = ldac_w;
    if (!pad_d[3] && !pad_d[2]) overlap++;
    if (frame_done) n_done++;
    if (in_ready && !pad_d[2]) rdy_err++;
    {p_ldac, p_sync, p_sdin, p_sclk} = pad_d;
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // present a word; returns after the accepting edge with in_valid still high
  task automatic send(input logic [23:0] w);
    bit ok = 1'b0;
    in_data = w; in_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      step(1);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic wait_quiet();
    int q = 0;
    for (int i = 0; i < 2000 && q < 3; i++) begin
      q = busy ? 0 : q + 1;
      step(1);
    end
    if (q < 3) begin
      checks++; errors++;
      $display("FAIL quiet_timeout busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset();
    int d0;
    step(2);
    checks++; if (pad_d !== 4'b1100) begin errors++; $display("FAIL rst_pad got %b exp 1100", pad_d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", in_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", frame_done); end
    rst = 1'b0;
    step(1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", in_ready); end
    // reset in the middle of SHIFT
    d0 = n_done;
    send(24'h3C3C3C);
    in_valid = 1'b0;
    step(12);
    #2 rst = 1'b1;
    #1;
    checks++; if (pad_d !== 4'b1100) begin errors++; $display("FAIL mid_rst_pad got %b exp 1100", pad_d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
    step(1);
    rst = 1'b0;
    step(2);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready got %b exp 1", in_ready); end
    checks++; if (n_done != d0) begin errors++; $display("FAIL mid_rst_done got %0d exp %0d", n_done - d0, 0); end
  endtask

  task automatic test_single_frame();
    int f0 = n_frames, d0 = n_done, l0 = n_ldac, v0 = sdin_viol;
    send(24'hA5F00F);
    in_valid = 1'b0; in_data = 24'h123456;
    wait_quiet();
    checks++; if (n_frames - f0 != 1) begin errors++; $display("FAIL single_frames got %0d exp 1", n_frames - f0); end
    checks++; if (last_word !== 32'h00A5F00F) begin errors++; $display("FAIL single_word got %h exp a5f00f", last_word); end
    checks++; if (last_nbits != 24) begin errors++; $display("FAIL single_sclk_falls got %0d exp 24", last_nbits); end
    checks++; if (last_low != 98) begin errors++; $display("FAIL single_sync_low got %0d exp 98", last_low); end
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL single_done got %0d exp 1", n_done - d0); end
    checks++; if (n_ldac - l0 != AUTO) begin errors++; $display("FAIL single_ldac got %0d exp %0d", n_ldac - l0, AUTO); end
    checks++; if (sdin_viol != v0) begin errors++; $display("FAIL single_sdin_stable got %0d exp 0", sdin_viol - v0); end
  endtask

  task automatic test_back_to_back();
    int f0 = n_frames, d0 = n_done, r0 = rdy_err;
    send(24'h000001);
    send(24'hFFFFFE);
    in_valid = 1'b0;
    wait_quiet();
    checks++; if (n_frames - f0 != 2) begin errors++; $display("FAIL b2b_frames got %0d exp 2", n_frames - f0); end
    checks++; if (fall_cyc - fall_prev != 103 + 2 * AUTO) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", fall_cyc - fall_prev, 103 + 2 * AUTO); end
    checks++; if (prev_word !== 32'h00000001) begin errors++; $display("FAIL b2b_word0 got %h exp 000001", prev_word); end
    checks++; if (last_word !== 32'h00FFFFFE) begin errors++; $display("FAIL b2b_word1 got %h exp fffffe", last_word); end
    checks++; if (rdy_err != r0) begin errors++; $display("FAIL b2b_ready_in_frame got %0d exp 0", rdy_err - r0); end
    checks++; if (n_done - d0 != 2) begin errors++; $display("FAIL b2b_done got %0d exp 2", n_done - d0); end
  endtask

  task automatic test_ldac_during_frame();
    int l0 = n_ldac, o0 = overlap;
    send(24'h5A5A5A);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(10);
      ldac_req = 1'b1; step(1); ldac_req = 1'b0;
    end
    wait_quiet();
    checks++; if (n_ldac - l0 != 1) begin errors++; $display("FAIL lfr_pulses got %0d exp 1", n_ldac - l0); end
    checks++; if (ldac_width != 2) begin errors++; $display("FAIL lfr_width got %0d exp 2", ldac_width); end
    checks++; if (ldac_fall - rise_cyc != 4) begin errors++; $display("FAIL lfr_after_gap got %0d exp 4", ldac_fall - rise_cyc); end
    checks++; if (overlap != o0) begin errors++; $display("FAIL lfr_sync_overlap got %0d exp 0", overlap - o0); end
  endtask

  task automatic test_idle_ldac();
    int l0 = n_ldac, f0, req_cyc;
    req_cyc = cyc;
    ldac_req = 1'b1; step(1); ldac_req = 1'b0;
    wait_quiet();
    checks++; if (n_ldac - l0 != 1) begin errors++; $display("FAIL idle_pulses got %0d exp 1", n_ldac - l0); end
    checks++; if (ldac_fall - req_cyc != 2) begin errors++; $display("FAIL idle_latency got %0d exp 2", ldac_fall - req_cyc); end
    checks++; if (ldac_width != 2) begin errors++; $display("FAIL idle_width got %0d exp 2", ldac_width); end
    // simultaneous request and accept: frame first
    l0 = n_ldac; f0 = n_frames;
    ldac_req = 1'b1;
    send(24'hC00003);
    ldac_req = 1'b0; in_valid = 1'b0;
    wait_quiet();
    checks++; if (n_frames - f0 != 1) begin errors++; $display("FAIL sim_frames got %0d exp 1", n_frames - f0); end
    checks++; if (last_word !== 32'h00C00003) begin errors++; $display("FAIL sim_word got %h exp c00003", last_word); end
    checks++; if (n_ldac - l0 != 1) begin errors++; $display("FAIL sim_pulses got %0d exp 1", n_ldac - l0); end
    checks++; if (ldac_fall - rise_cyc != 4) begin errors++; $display("FAIL sim_after_gap got %0d exp 4", ldac_fall - rise_cyc); end
  endtask

  task automatic test_three_frames();
    int l0 = n_ldac;
    send(24'h111111); in_valid = 1'b0; wait_quiet();
    send(24'h222222); in_valid = 1'b0;
    step(20);
    ldac_req = 1'b1; step(1); ldac_req = 1'b0;
    wait_quiet();
    checks++; if (ldac_fall - rise_cyc != 4) begin errors++; $display("FAIL tri_f2_after_gap got %0d exp 4", ldac_fall - rise_cyc); end
    send(24'h333333); in_valid = 1'b0; wait_quiet();
    checks++; if (n_ldac - l0 != 1 + 2 * AUTO) begin errors++; $display("FAIL tri_pulses got %0d exp %0d", n_ldac - l0, 1 + 2 * AUTO); end
    checks++; if (last_word !== 32'h00333333) begin errors++; $display("FAIL tri_word got %h exp 333333", last_word); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ldac_during_frame();
    test_idle_ldac();
    test_three_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_dac_serializer.md
Name: dm_dac_serializer

Overview:
- Serial DAC frame generator for the deformable-mirror actuator interface.
- Accepts parallel DAC command words over a valid/ready handshake and drives the 4-bit LVCMOS33 output pad bank directly as SCLK, SDIN, SYNC_n and LDAC_n.
- Sits immediately upstream of the 4-bit output buffer wrapper; its pad_d bus connects 1:1 to that wrapper's D[3:0].

Parameters:
- WORD_BITS, 24, DAC command word length, shifted MSB first; legal range 8..32.
- DIV, 2, SCLK half-period in clk cycles; must be >= 1.
- GAP_CYC, 4, minimum SYNC_n-high cycles after a frame before the next frame or LDAC pulse; must be >= 1.
- LDAC_CYC, 2, LDAC_n low-pulse width in clk cycles; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WORD_BITS  DAC command word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ldac_req  input  1  single-cycle request for an LDAC_n pulse.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse when SYNC_n returns high.
- pad_d  output  4  [0]=SCLK, [1]=SDIN, [2]=SYNC_n, [3]=LDAC_n; feeds the output buffer D[3:0].

Behaviour:
- Reset is asynchronous and active-high. While rst=1: pad_d=4'b1100 (SCLK=0, SDIN=0, SYNC_n=1, LDAC_n=1), in_ready=0, busy=0, frame_done=0, ldac_pending=0, state=IDLE.
- Reset asserted mid-frame forces the same values immediately. The in-flight word is discarded and no partial-frame completion occurs.
- All outputs are registered. No combinational path from any input to pad_d.
- The state machine has six states:
  - IDLE: in_ready=1. A transfer is accepted when in_valid && in_ready. The word is latched into the shift register and the FSM goes to SETUP. Otherwise, if ldac_pending is set, go to LDAC.
  - SETUP: lasts DIV cycles. SYNC_n=0, SCLK=0, SDIN=word[WORD_BITS-1].
  - SHIFT: WORD_BITS bit periods of 2*DIV cycles each. In each bit period, SCLK=1 for DIV cycles, then SCLK=0 for DIV cycles.
    - SDIN updates only on SCLK rising and stays stable across the falling edge, where the DAC samples.
    - Bit k (MSB first) is held for its entire period.
  - GAP: SYNC_n=1 and SCLK=0 for GAP_CYC cycles. frame_done pulses on the first GAP cycle. SDIN is returned to 0.
    - At the end of GAP, go to LDAC if ldac_pending is set, else go to IDLE.
  - LDAC: LDAC_n=0 for LDAC_CYC cycles and ldac_pending clears. Then LDAC_n=1 and the FSM returns to IDLE.
    - LDAC is never asserted while SYNC_n=0.
- Frame length: SYNC_n is low for exactly DIV + 2*DIV*WORD_BITS cycles. Exactly WORD_BITS SCLK falling edges occur while SYNC_n=0.
- Throughput: minimum spacing between SYNC_n falling edges is DIV + 2*DIV*WORD_BITS + GAP_CYC + 1 cycles, where the +1 is the IDLE accept cycle.
- ldac_req sets ldac_pending in any state.
  - A request during a frame is serviced after that frame's GAP.
  - Multiple requests before service collapse into one pulse.
  - A request arriving in the same cycle as pending is cleared is retained and serviced on a later pass.
- ldac_req and an accepted in_valid in the same IDLE cycle: the frame goes first, then the LDAC pulse.
- in_data is sampled only on the accept cycle. Later changes to in_data have no effect.
- The bit counter and DIV counter are sized with $clog2 and need no wrap handling beyond their terminal counts.

Optional Feature:
- Macro: DM_DAC_AUTO_LDAC_EN.
- Defined: every completed frame sets ldac_pending at GAP entry, so each frame is followed by an LDAC_n pulse. ldac_req still works and merges with the auto request, giving one pulse.
- Undefined: LDAC_n pulses only in response to ldac_req. Multiple frames can be loaded and updated simultaneously with a single request.

Test Plan:
- Reset value check: assert rst mid-frame, after 10 cycles of SHIFT → pad_d=4'b1100 asynchronously, busy=0, in_ready=0. After release, in_ready=1 and the next frame is clean.
- Single frame, DIV=2, WORD_BITS=24, in_data=24'hA5F00F, macro undefined → SYNC_n low for 98 cycles; 24 SCLK falling edges; sampled bits equal 0xA5F00F MSB first; frame_done pulses once; LDAC_n stays 1.
- Back-to-back: in_valid held high with words 24'h000001 then 24'hFFFFFE → second SYNC_n fall occurs 103 cycles after the first (DIV=2, GAP_CYC=4); decoded words match; in_ready low throughout each frame.
- LDAC during frame: pulse ldac_req 3 times during a frame → exactly one LDAC_n low pulse of 2 cycles, starting after the 4-cycle GAP; SYNC_n=1 during the pulse.
- Idle LDAC plus simultaneous accept: ldac_req alone in IDLE → LDAC_n low 2 cycles starting 2 cycles later. Then ldac_req and in_valid in the same cycle → frame first, LDAC pulse after GAP.
- DM_DAC_AUTO_LDAC_EN defined, 3 consecutive frames, DIV=1 → 3 LDAC_n pulses, one after each GAP. An extra ldac_req during frame 2 does not produce a fourth pulse.
